eddy_sensor_acq_multi: RTL and testbench

- Parametrised successor to the single-sensor eddy current acquisition IP.
- Drives a shared conversion strobe (CNV) and serial clock (SCLK) to NUM_CH serial ADCs, each with its own MISO line.
- Shifts DATA_WIDTH bits per channel in parallel and publishes a sample set with valid pulse, sample counter and overrun flag.
- Sits between the sensor connector pins and the AXI4-Lite register slave, which supplies configuration and reads results.

---
 rtl/eddy_acq_pkg.sv | 11 +
 rtl/eddy_sensor_acq_multi_if.sv | 30 +++
 rtl/eddy_sclk_gen.sv | 41 ++++
 rtl/eddy_sensor_acq_multi.sv | 78 +++++++
 tb/tb_eddy_sensor_acq_multi.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/eddy_acq_pkg.sv
// eddy_acq_pkg: shared FSM states, width limits and the zero-to-one clamp
package eddy_acq_pkg;
  typedef enum logic [1:0] {IDLE, CONV, SHIFT, LATCH} state_e;
  localparam int MAX_CH = 8;
  localparam int MIN_DW = 8;
  localparam int MAX_DW = 32;
  localparam int BIT_W  = 6;
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction
endpackage

// File: rtl/eddy_sensor_acq_multi_if.sv
// eddy_sensor_acq_multi_if: configuration, sensor pins and result bus of the acquisition block
interface eddy_sensor_acq_multi_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 18,
  parameter int DIV_W      = 8,
  parameter int CONV_W     = 10,
  parameter int CNT_W      = 16
);
  logic                         enable;
  logic                         trigger;
  logic [DIV_W-1:0]             sclk_div;
  logic [CONV_W-1:0]            conv_cycles;
  logic                         clr_overrun;
  logic [NUM_CH-1:0]            miso;
  logic                         sclk;
  logic                         cnv;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic                         data_valid;
  logic                         busy;
  logic                         overrun;
  logic [CNT_W-1:0]             sample_count;
  modport slave (
    input  enable, trigger, sclk_div, conv_cycles, clr_overrun, miso,
    output sclk, cnv, data_out, data_valid, busy, overrun, sample_count
  );
  modport master (
    output enable, trigger, sclk_div, conv_cycles, clr_overrun, miso,
    input  sclk, cnv, data_out, data_valid, busy, overrun, sample_count
  );
endinterface

// File: rtl/eddy_sclk_gen.sv
// eddy_sclk_gen: divided serial clock with fall strobe and bit counting for one frame
module eddy_sclk_gen
  import eddy_acq_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int DATA_WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             fall_strobe,
  output logic             done
);
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d, wrap;
  // half-period counter toggles sclk; a fall ends each bit, the last fall ends the frame
  always_comb begin
    wrap        = div_cnt_q == div - 1'b1;
    fall_strobe = en & sclk_q & wrap;
    done        = fall_strobe & (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
    div_cnt_d   = (!en || wrap) ? '0 : div_cnt_q + 1'b1;
    sclk_d      = en & (wrap ? ~sclk_q : sclk_q);
    bit_cnt_d   = en ? bit_cnt_q + BIT_W'(fall_strobe) : '0;
  end
  // state registers, cleared asynchronously so sclk drops at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
    end
  end
  assign sclk = sclk_q;
endmodule

// File: rtl/eddy_sensor_acq_multi.sv
// eddy_sensor_acq_multi: drives shared CNV/SCLK to NUM_CH serial ADCs and publishes sample sets
module eddy_sensor_acq_multi
  import eddy_acq_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 18,
  parameter int DIV_W      = 8,
  parameter int CONV_W     = 10,
  parameter int CNT_W      = 16
) (
  input logic ACLK,
  input logic ARESET,
  eddy_sensor_acq_multi_if.slave bus
);
  state_e                             state_q, state_d;
  logic [DIV_W-1:0]                   d_q, d_d;
  logic [CONV_W-1:0]                  c_q, c_d, conv_cnt_q, conv_cnt_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  sr_q, sr_d, data_out_q, data_out_d;
  logic                               data_valid_q, data_valid_d, overrun_q, overrun_d;
  logic [CNT_W-1:0]                   sample_count_q, sample_count_d;
  logic                               sclk, fall, done, busy;
  assign busy = state_q != IDLE;
  eddy_sclk_gen #(.DIV_W(DIV_W), .DATA_WIDTH(DATA_WIDTH)) u_sclk (
    .clk(ACLK), .rst(ARESET), .en(state_q == SHIFT), .div(d_q),
    .sclk(sclk), .fall_strobe(fall), .done(done)
  );
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sr_d[i] = fall ? {sr_q[i][DATA_WIDTH-2:0], bus.miso[i]} : sr_q[i];
  end
  // frame sequencing, idle-time config capture, sticky overrun and the result latch
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable && bus.trigger) state_d = CONV;
      CONV:    if (conv_cnt_q == c_q - 1'b1) state_d = SHIFT;
      SHIFT:   if (done) state_d = LATCH;
      default: state_d = IDLE;
    endcase
    d_d            = busy ? d_q : DIV_W'(clamp1(32'(bus.sclk_div)));
    c_d            = busy ? c_q : CONV_W'(clamp1(32'(bus.conv_cycles)));
    conv_cnt_d     = (state_q == CONV) ? conv_cnt_q + 1'b1 : '0;
    overrun_d      = ~bus.clr_overrun & (overrun_q | (bus.trigger & busy));
    data_valid_d   = done;
    data_out_d     = done ? sr_d : data_out_q;
    sample_count_d = sample_count_q + CNT_W'(done);
  end
  // all state cleared asynchronously so pins return to idle without a clock
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q        <= IDLE;
      d_q            <= '0;
      c_q            <= '0;
      conv_cnt_q     <= '0;
      sr_q           <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      overrun_q      <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      d_q            <= d_d;
      c_q            <= c_d;
      conv_cnt_q     <= conv_cnt_d;
      sr_q           <= sr_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      overrun_q      <= overrun_d;
      sample_count_q <= sample_count_d;
    end
  end
  assign bus.sclk         = sclk;
  assign bus.cnv          = state_q == CONV;
  assign bus.busy         = busy;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.sample_count = sample_count_q;
endmodule

// File: tb/tb_eddy_sensor_acq_multi.sv
// tb_eddy_sensor_acq_multi: directed vector and sequence checks of the acquisition block
module tb_eddy_sensor_acq_multi;
  localparam int NC = 2;
  localparam int DW = 18;
  localparam int CW = 4;
  typedef struct {
    logic [7:0]  div;
    logic [9:0]  conv;
    logic [17:0] w0;
    logic [17:0] w1;
    int          lat;
    int          cnv_n;
    int          hi_n;
  } vec_t;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [17:0] adc_w [NC];
  int idx = DW - 1;
  int errors = 0;
  int checks = 0;
  vec_t vecs [4];
  eddy_sensor_acq_multi_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .DIV_W(8), .CONV_W(10), .CNT_W(CW)) bus ();
  eddy_sensor_acq_multi #(.NUM_CH(NC), .DATA_WIDTH(DW), .DIV_W(8), .CONV_W(10), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus)
  );
  always #5 ACLK = ~ACLK;
  always @(negedge bus.sclk or posedge bus.cnv) idx <= bus.cnv ? DW - 1 : idx - 1;
  assign bus.miso = (idx >= 0 && idx < DW) ? {adc_w[1][idx], adc_w[0][idx]} : 2'b00;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wait_dv(output int n);
    n = 0;
    while (!bus.data_valid && n < 1000) begin
      @(negedge ACLK);
      n++;
    end
  endtask
  task automatic run_frame(input vec_t v, input int drop_at, output int lat, output int cnv_n, output int hi_n);
    adc_w[0] = v.w0;
    adc_w[1] = v.w1;
    bus.sclk_div = v.div;
    bus.conv_cycles = v.conv;
    @(negedge ACLK);
    bus.trigger = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    bus.sclk_div = 8'd5;
    bus.conv_cycles = 10'd7;
    lat = 1;
    cnv_n = 0;
    hi_n = 0;
    while (!bus.data_valid && lat < 1000) begin
      cnv_n += int'(bus.cnv);
      hi_n += int'(bus.sclk);
      if (lat == drop_at) bus.enable = 1'b0;
      @(negedge ACLK);
      lat++;
    end
  endtask
  initial begin
    int lat, cn, hn, n;
    vecs[0] = '{8'd2, 10'd10, 18'h2A5A5, 18'h15A5A, 83, 10, 36};
    vecs[1] = '{8'd0, 10'd0, 18'h3FFFF, 18'h00001, 38, 1, 18};
    vecs[2] = '{8'd1, 10'd3, 18'h20000, 18'h1FFFF, 40, 3, 18};
    vecs[3] = '{8'd3, 10'd1, 18'h12345, 18'h0ABCD, 110, 1, 54};
    adc_w[0] = '0;
    adc_w[1] = '0;
    bus.enable = 1'b1;
    bus.trigger = 1'b0;
    bus.clr_overrun = 1'b0;
    bus.sclk_div = 8'd2;
    bus.conv_cycles = 10'd10;
    #2;
    chk("rst_sclk", 64'(bus.sclk), 0);
    chk("rst_cnv", 64'(bus.cnv), 0);
    chk("rst_data", 64'(bus.data_out), 0);
    chk("rst_valid", 64'(bus.data_valid), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_overrun", 64'(bus.overrun), 0);
    chk("rst_count", 64'(bus.sample_count), 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], 0, lat, cn, hn);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_cnv_cycles", i), 64'(cn), 64'(vecs[i].cnv_n));
      chk($sformatf("v%0d_sclk_high", i), 64'(hn), 64'(vecs[i].hi_n));
      chk($sformatf("v%0d_ch0", i), 64'(bus.data_out[17:0]), 64'(vecs[i].w0));
      chk($sformatf("v%0d_ch1", i), 64'(bus.data_out[35:18]), 64'(vecs[i].w1));
      chk($sformatf("v%0d_count", i), 64'(bus.sample_count), 64'(i + 1));
      @(negedge ACLK);
      chk($sformatf("v%0d_valid_pulse", i), 64'(bus.data_valid), 0);
      chk($sformatf("v%0d_idle", i), 64'(bus.busy), 0);
    end
    bus.sclk_div = 8'd2;
    bus.conv_cycles = 10'd10;
    @(negedge ACLK);
    bus.trigger = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    repeat (19) @(negedge ACLK);
    bus.trigger = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    chk("ovr_set", 64'(bus.overrun), 1);
    wait_dv(n);
    chk("ovr_frame_done", 64'(n < 1000), 1);
    chk("ovr_count", 64'(bus.sample_count), 5);
    repeat (100) @(negedge ACLK);
    chk("ovr_no_second_frame", 64'(bus.sample_count), 5);
    chk("ovr_sticky", 64'(bus.overrun), 1);
    bus.trigger = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    repeat (5) @(negedge ACLK);
    bus.trigger = 1'b1;
    bus.clr_overrun = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    bus.clr_overrun = 1'b0;
    chk("ovr_clr_priority", 64'(bus.overrun), 0);
    wait_dv(n);
    chk("ovr_clr_count", 64'(bus.sample_count), 6);
    @(negedge ACLK);
    bus.trigger = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    repeat (48) @(negedge ACLK);
    chk("mid_sclk_high", 64'(bus.sclk), 1);
    ARESET = 1'b1;
    #1;
    chk("arst_sclk", 64'(bus.sclk), 0);
    chk("arst_cnv", 64'(bus.cnv), 0);
    chk("arst_busy", 64'(bus.busy), 0);
    chk("arst_data", 64'(bus.data_out), 0);
    chk("arst_count", 64'(bus.sample_count), 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    run_frame(vecs[0], 0, lat, cn, hn);
    chk("post_rst_latency", 64'(lat), 83);
    chk("post_rst_ch0", 64'(bus.data_out[17:0]), 64'(18'h2A5A5));
    chk("post_rst_ch1", 64'(bus.data_out[35:18]), 64'(18'h15A5A));
    chk("post_rst_count", 64'(bus.sample_count), 1);
    for (int i = 0; i < 14; i++) run_frame(vecs[1], 0, lat, cn, hn);
    chk("wrap_pre", 64'(bus.sample_count), 15);
    run_frame(vecs[1], 0, lat, cn, hn);
    chk("wrap_valid", 64'(bus.data_valid), 1);
    chk("wrap_zero", 64'(bus.sample_count), 0);
    run_frame(vecs[0], 5, lat, cn, hn);
    chk("en_drop_latency", 64'(lat), 83);
    chk("en_drop_ch0", 64'(bus.data_out[17:0]), 64'(18'h2A5A5));
    chk("en_drop_count", 64'(bus.sample_count), 1);
    @(negedge ACLK);
    bus.trigger = 1'b1;
    @(negedge ACLK);
    bus.trigger = 1'b0;
    chk("en_off_busy", 64'(bus.busy), 0);
    chk("en_off_cnv", 64'(bus.cnv), 0);
    repeat (100) @(negedge ACLK);
    chk("en_off_count", 64'(bus.sample_count), 1);
    chk("en_off_overrun", 64'(bus.overrun), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
